// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the four-digit common-anode seven-segment scanner:
// active-low segment patterns, blank/off codes and the digit count.
package seg7_scan_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  localparam logic [7:0] BLANK_PATTERN = 8'hFF;
  localparam logic [3:0] ANODE_OFF     = 4'b1111;
  localparam logic [6:0] SEG_OFF       = 7'h7F;

  // Active-low {dp,g..a} patterns for hex 0..F, decimal point off.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-seven-segment decoder with blanking and decimal point.
// Blanking only forces the segments off; the decimal point is independent.
module seg7_hex_decoder
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] pattern_o
);

  logic [7:0] lut_val;

  always_comb begin
    lut_val   = SEG_LUT[value_i];
    pattern_o = {~dp_i, (blank_i ? SEG_OFF : lut_val[6:0])};
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for a four-digit common-anode display. Digits are
// snapshotted once per frame so a frame never mixes old and new values.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_WIDTH   = 17
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [15:0] DIGIT_IN,
  input  logic [3:0]  DOT_IN,
  input  logic        BLANK_LEAD,
  output logic [3:0]  SEG_SELECT_OUT,
  output logic [7:0]  HEX_OUT
);

  localparam logic [DIV_WIDTH-1:0] P_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

  logic [DIV_WIDTH-1:0] p_q, p_d;
  logic [IDX_W-1:0]     d_q, d_d;
  logic [15:0]          snap_digits_q, snap_digits_d;
  logic [3:0]           snap_dots_q, snap_dots_d;
  logic [3:0]           sel_q, sel_d;
  logic [7:0]           hex_q, hex_d;

  logic       tick;
  logic [3:0] lead_zero;
  logic [3:0] cur_value;
  logic       cur_blank;
  logic       cur_dp;
  logic [7:0] cur_pattern;

  assign tick = ENABLE && (p_q == P_LAST);

  always_comb begin
    p_d           = p_q;
    d_d           = d_q;
    snap_digits_d = snap_digits_q;
    snap_dots_d   = snap_dots_q;
    if (ENABLE) begin
      p_d = tick ? '0 : p_q + 1'b1;
    end
    if (tick) begin
      d_d = d_q + 1'b1;
      if (d_q == IDX_W'(NUM_DIGITS - 1)) begin
        snap_digits_d = DIGIT_IN;
        snap_dots_d   = DOT_IN;
      end
    end
  end

  // lead_zero[k]: snapshot digits k..3 are all zero; digit 0 is never blanked.
  always_comb begin
    lead_zero[3] = (snap_digits_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (snap_digits_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (snap_digits_q[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
  end

  always_comb begin
    cur_value = snap_digits_q[{d_q, 2'b00} +: 4];
    cur_blank = BLANK_LEAD && lead_zero[d_q];
    cur_dp    = snap_dots_q[d_q];
  end

  seg7_hex_decoder u_decoder (
    .value_i   (cur_value),
    .blank_i   (cur_blank),
    .dp_i      (cur_dp),
    .pattern_o (cur_pattern)
  );

  // Anode and segments are registered together so they switch on the same edge.
  always_comb begin
    if (ENABLE) begin
      sel_d = ~(4'b0001 << d_q);
      hex_d = cur_pattern;
    end else begin
      sel_d = ANODE_OFF;
      hex_d = BLANK_PATTERN;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      p_q           <= '0;
      d_q           <= '0;
      snap_digits_q <= '0;
      snap_dots_q   <= '0;
      sel_q         <= ANODE_OFF;
      hex_q         <= BLANK_PATTERN;
    end else begin
      p_q           <= p_d;
      d_q           <= d_d;
      snap_digits_q <= snap_digits_d;
      snap_dots_q   <= snap_dots_d;
      sel_q         <= sel_d;
      hex_q         <= hex_d;
    end
  end

  assign SEG_SELECT_OUT = sel_q;
  assign HEX_OUT        = hex_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with REFRESH_DIV=4. Edge numbers below
// count rising edges since the most recent reset release.
module tb_seg7_scan_display;

  logic        CLK;
  logic        RESET;
  logic        ENABLE;
  logic [15:0] DIGIT_IN;
  logic [3:0]  DOT_IN;
  logic        BLANK_LEAD;
  logic [3:0]  SEG_SELECT_OUT;
  logic [7:0]  HEX_OUT;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  seg7_scan_display #(
    .REFRESH_DIV (4),
    .DIV_WIDTH   (3)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .ENABLE         (ENABLE),
    .DIGIT_IN       (DIGIT_IN),
    .DOT_IN         (DOT_IN),
    .BLANK_LEAD     (BLANK_LEAD),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .HEX_OUT        (HEX_OUT)
  );

  // Clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to the given edge count, then settle 1 time unit past the edge.
  task automatic go_to(input int target);
    while (cyc < target) begin
      @(posedge CLK);
      cyc++;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp_sel,
                       input logic [7:0] exp_hex);
    n_checks++;
    assert ({SEG_SELECT_OUT, HEX_OUT} === {exp_sel, exp_hex}) else begin
      n_errors++;
      $error("FAIL %s: got sel=%b hex=%h, expected sel=%b hex=%h",
             tag, SEG_SELECT_OUT, HEX_OUT, exp_sel, exp_hex);
    end
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #1 RESET = 1'b1;
    cyc = 0;
  endtask

  initial begin
    RESET      = 1'b0;
    ENABLE     = 1'b1;
    DIGIT_IN   = 16'h1234;
    DOT_IN     = 4'b0000;
    BLANK_LEAD = 1'b0;

    repeat (3) @(posedge CLK);
    #1 check("reset_state", 4'b1111, 8'hFF);
    release_reset();

    // First frame shows the zero snapshot, no blanking
    go_to(1);  check("first_lit_d0", 4'b1110, 8'hC0);
    go_to(5);  check("first_frame_d1", 4'b1101, 8'hC0);

    // Second frame shows 1234
    go_to(17); check("f2_d0_start", 4'b1110, 8'h99);
    go_to(20); check("f2_d0_hold", 4'b1110, 8'h99);
    go_to(21); check("f2_d1", 4'b1101, 8'hB0);
    go_to(25); check("f2_d2", 4'b1011, 8'hA4);
    go_to(29); check("f2_d3", 4'b0111, 8'hF9);
    go_to(32); check("f2_d3_hold", 4'b0111, 8'hF9);

    // Anti-tear: change inputs while d=1 of the third frame
    go_to(37); DIGIT_IN = 16'h5678;
    go_to(41); check("tear_d2", 4'b1011, 8'hA4);
    go_to(45); check("tear_d3", 4'b0111, 8'hF9);
    go_to(49); check("new_d0", 4'b1110, 8'h80);
    go_to(53); check("new_d1", 4'b1101, 8'hF8);
    go_to(57); check("new_d2", 4'b1011, 8'h82);
    go_to(61); check("new_d3", 4'b0111, 8'h92);

    // Leading-zero blanking with 0070
    BLANK_LEAD = 1'b1;
    DIGIT_IN   = 16'h0070;
    go_to(65); check("blank_d0", 4'b1110, 8'hC0);
    go_to(69); check("blank_d1", 4'b1101, 8'hF8);
    go_to(73); check("blank_d2", 4'b1011, 8'hFF);
    go_to(77); check("blank_d3", 4'b0111, 8'hFF);

    // All zero with a dot on digit 2
    DIGIT_IN = 16'h0000;
    DOT_IN   = 4'b0100;
    go_to(81); check("zero_d0", 4'b1110, 8'hC0);
    go_to(85); check("zero_d1", 4'b1101, 8'hFF);

    // Enable gating at d=1, p=2
    go_to(86); ENABLE = 1'b0;
    go_to(87); check("disable_off", 4'b1111, 8'hFF);
    go_to(92); check("disable_hold", 4'b1111, 8'hFF);
    go_to(96); ENABLE = 1'b1;
    go_to(97); check("resume_d1_a", 4'b1101, 8'hFF);
    go_to(98); check("resume_d1_b", 4'b1101, 8'hFF);
    go_to(99); check("dot_d2", 4'b1011, 8'h7F);
    go_to(103); check("dot_d3", 4'b0111, 8'hFF);

    // Input change on the snapshot edge itself is captured
    go_to(105); DIGIT_IN = 16'h000A;
    go_to(107); check("edge_capture", 4'b1110, 8'h88);

    // Asynchronous reset while d=2
    go_to(115);
    RESET = 1'b0;
    #1 check("async_reset", 4'b1111, 8'hFF);
    @(posedge CLK);
    release_reset();
    go_to(1); check("post_reset_d0", 4'b1110, 8'hC0);
    go_to(4); check("post_reset_d0_hold", 4'b1110, 8'hC0);
    go_to(5); check("post_reset_d1", 4'b1101, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
